// File: rtl/mux_pkg.sv
// Shared constants and helpers for the mux2to1/mux4to1 selector family.
package mux_pkg;

  localparam int unsigned SEL2_W = 1;
  localparam int unsigned SEL4_W = 2;

  // Extract lane k of width w (w <= 32) from a packed lane vector.
  function automatic logic [31:0] lane(logic [127:0] in, int unsigned k, int unsigned w);
    logic [127:0] shifted;
    shifted = in >> (k * w);
    return shifted[31:0] & ((32'h1 << w) - 32'h1);
  endfunction

endpackage

// File: rtl/mux2to1.sv
// 2:1 lane selector; an unknown SEL yields X in simulation rather than a lane.
module mux2to1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [2*WIDTH-1:0] IN,
  input  logic [SEL2_W-1:0]  SEL,
  output logic [WIDTH-1:0]   OUT
);

  always_comb begin
    OUT = 'x;
    if (SEL == 1'b1) begin
      OUT = IN[2*WIDTH-1:WIDTH];
    end else if (SEL == 1'b0) begin
      OUT = IN[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mux4to1.sv
// 4:1 lane selector built from three mux2to1 stages, plus an enabled registered copy.
module mux4to1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [4*WIDTH-1:0]   IN,
  input  logic [SEL4_W-1:0]    SEL,
  input  logic                 EN,
  output logic [WIDTH-1:0]     OUT,
  output logic [WIDTH-1:0]     OUT_Q
);

  logic [WIDTH-1:0] stage_a;
  logic [WIDTH-1:0] stage_b;

  mux2to1 #(.WIDTH(WIDTH)) u_stage_a (
    .IN  (IN[2*WIDTH-1:0]),
    .SEL (SEL[0]),
    .OUT (stage_a)
  );

  mux2to1 #(.WIDTH(WIDTH)) u_stage_b (
    .IN  (IN[4*WIDTH-1:2*WIDTH]),
    .SEL (SEL[0]),
    .OUT (stage_b)
  );

  mux2to1 #(.WIDTH(WIDTH)) u_final (
    .IN  ({stage_b, stage_a}),
    .SEL (SEL[1]),
    .OUT (OUT)
  );

  // Reset takes priority over EN.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      OUT_Q <= '0;
    end else if (EN) begin
      OUT_Q <= OUT;
    end
  end

endmodule

// File: tb/tb_mux4to1.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops and compares after each edge.
module tb_mux4to1;
  import mux_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] in32;
  logic [1:0]  sel;
  logic [7:0]  out8;
  logic [7:0]  out_q8;

  logic [3:0]  in1;
  logic [1:0]  sel1;
  logic        out1;
  logic        out_q1;

  logic [7:0]  in81;
  logic [2:0]  sel81;
  logic        lo81;
  logic        hi81;
  logic        out81;
  logic        lo_q81;
  logic        hi_q81;

  always #5 clk = ~clk;

  mux4to1 #(.WIDTH(8)) dut (
    .CLK(clk), .RESET_N(rst_n), .IN(in32), .SEL(sel), .EN(en), .OUT(out8), .OUT_Q(out_q8)
  );

  mux4to1 #(.WIDTH(1)) dut_w1 (
    .CLK(clk), .RESET_N(rst_n), .IN(in1), .SEL(sel1), .EN(en), .OUT(out1), .OUT_Q(out_q1)
  );

  mux4to1 #(.WIDTH(1)) u81_lo (
    .CLK(clk), .RESET_N(rst_n), .IN(in81[3:0]), .SEL(sel81[1:0]), .EN(en), .OUT(lo81),
    .OUT_Q(lo_q81)
  );

  mux4to1 #(.WIDTH(1)) u81_hi (
    .CLK(clk), .RESET_N(rst_n), .IN(in81[7:4]), .SEL(sel81[1:0]), .EN(en), .OUT(hi81),
    .OUT_Q(hi_q81)
  );

  mux2to1 #(.WIDTH(1)) u81_final (
    .IN({hi81, lo81}), .SEL(sel81[2]), .OUT(out81)
  );

  typedef struct {
    logic [7:0] exp8;
    logic [7:0] expq8;
    logic       exp1;
    logic       expq1;
    logic       exp81;
  } item_t;

  item_t      sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_q8;
  logic       model_q1;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [31:0] i32,
                       input logic [1:0] s, input logic [10:0] sweep);
    item_t      it;
    logic [31:0] l;
    @(negedge clk);
    rst_n = r;
    en    = e;
    in32  = i32;
    sel   = s;
    in1   = sweep[5:2];
    sel1  = sweep[1:0];
    in81  = sweep[10:3];
    sel81 = sweep[2:0];
    l = lane(128'(i32), 32'(s), 8);
    it.exp8  = l[7:0];
    it.exp1  = in1[sel1];
    it.exp81 = in81[sel81];
    if (!r) begin
      model_q8 = 8'h00;
      model_q1 = 1'b0;
    end else if (e) begin
      model_q8 = it.exp8;
      model_q1 = it.exp1;
    end
    it.expq8 = model_q8;
    it.expq1 = model_q1;
    sb_q.push_back(it);
  endtask

  // Inputs change only on negedges, so OUT is still valid for the cycle just clocked.
  always @(posedge clk) begin
    item_t it;
    #1;
    if (sb_q.size() != 0) begin
      it = sb_q.pop_front();
      check8("out8", out8, it.exp8);
      check8("out_q8", out_q8, it.expq8);
      check8("out_w1", {7'b0, out1}, {7'b0, it.exp1});
      check8("out_q_w1", {7'b0, out_q1}, {7'b0, it.expq1});
      check8("out_8to1", {7'b0, out81}, {7'b0, it.exp81});
    end
  end

  initial begin
    logic [31:0] pat;
    pat      = 32'hDDCC_BBAA;
    model_q8 = 8'h00;
    model_q1 = 1'b0;
    rst_n = 1'b0; en = 1'b0; in32 = '0; sel = '0;
    in1 = '0; sel1 = '0; in81 = '0; sel81 = '0;

    drive(1'b0, 1'b0, pat, 2'd0, 11'd0);   // reset, OUT=AA
    drive(1'b1, 1'b1, pat, 2'd2, 11'd1);   // OUT_Q <- CC
    drive(1'b0, 1'b1, pat, 2'd1, 11'd2);   // reset beats EN, OUT=BB
    drive(1'b1, 1'b1, pat, 2'd3, 11'd3);   // OUT_Q <- DD
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, pat, 2'd0, 11'(4 + k));  // hold DD
    drive(1'b1, 1'b1, pat, 2'd1, 11'd7);   // OUT_Q <- BB

    for (int i = 0; i < 2048; i++) begin
      drive(($urandom_range(0, 15) != 0), 1'($urandom), $urandom, 2'($urandom), 11'(i));
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
